// File: rtl/spu_dual_issue_dispatch.sv
// SPU dual-issue dispatch stage. Holds one program-ordered pair from decode and issues it
// to the even/odd register-fetch ports, gated by a per-register latency scoreboard.
module spu_dual_issue_dispatch #(
  parameter int REG_ADDR_WIDTH       = 7,
  parameter int UNIT_ID_SIZE         = 3,
  parameter int INTERNAL_OPCODE_SIZE = 11,
  parameter int NOP_OPCODE           = 0,
  parameter int LAT_W                = 3,
  parameter int SLOT_W = 1+1+1+3+LAT_W+UNIT_ID_SIZE+INTERNAL_OPCODE_SIZE+4*REG_ADDR_WIDTH+18
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SLOT_W-1:0]               in_slot0,
  input  logic [SLOT_W-1:0]               in_slot1,
  input  logic [31:0]                     in_pc,
  input  logic                            branch_taken,
  output logic [UNIT_ID_SIZE-1:0]         rf_unit_id_even,
  output logic [UNIT_ID_SIZE-1:0]         rf_unit_id_odd,
  output logic [INTERNAL_OPCODE_SIZE-1:0] rf_opcode_even,
  output logic [INTERNAL_OPCODE_SIZE-1:0] rf_opcode_odd,
  output logic [REG_ADDR_WIDTH-1:0]       addr_ra_rd_even,
  output logic [REG_ADDR_WIDTH-1:0]       addr_rb_rd_even,
  output logic [REG_ADDR_WIDTH-1:0]       addr_rc_rd_even,
  output logic [REG_ADDR_WIDTH-1:0]       addr_ra_rd_odd,
  output logic [REG_ADDR_WIDTH-1:0]       addr_rb_rd_odd,
  output logic [REG_ADDR_WIDTH-1:0]       addr_rc_rd_odd,
  output logic [REG_ADDR_WIDTH-1:0]       rf_addr_rt_wt_even,
  output logic [REG_ADDR_WIDTH-1:0]       rf_addr_rt_wt_odd,
  output logic [6:0]                      rf_imm7_even,
  output logic [6:0]                      rf_imm7_odd,
  output logic [9:0]                      rf_imm10_even,
  output logic [9:0]                      rf_imm10_odd,
  output logic [15:0]                     rf_imm16_odd,
  output logic [17:0]                     rf_imm18_odd,
  output logic [31:0]                     PC,
  output logic                            br_first_instr
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;

  typedef struct packed {
    logic                            valid;
    logic                            pipe;
    logic                            is_branch;
    logic                            uses_ra, uses_rb, uses_rc;
    logic [LAT_W-1:0]                lat;
    logic [UNIT_ID_SIZE-1:0]         unit_id;
    logic [INTERNAL_OPCODE_SIZE-1:0] opcode;
    logic [REG_ADDR_WIDTH-1:0]       ra, rb, rc, rt;
    logic [17:0]                     imm18;
  } slot_t;

  typedef struct packed {
    logic [UNIT_ID_SIZE-1:0]         unit_id;
    logic [INTERNAL_OPCODE_SIZE-1:0] opcode;
    logic [REG_ADDR_WIDTH-1:0]       ra, rb, rc, rt;
  } pipe_out_t;

  typedef enum logic [1:0] {EMPTY, PAIR, SECOND} state_e;

  localparam pipe_out_t NOP_PIPE = '{unit_id: '0, opcode: INTERNAL_OPCODE_SIZE'(NOP_OPCODE),
                                     ra: '0, rb: '0, rc: '0, rt: '0};

  slot_t            in0, in1;
  slot_t            held_q [2];
  state_e           state_q, state_d;
  logic [31:0]      pc_q;
  logic [LAT_W-1:0] sb_q [NREG];
  logic [LAT_W-1:0] sb_d [NREG];
  logic             issue0, issue1, held_done, accept;
  logic [1:0]       go;
  pipe_out_t        even_d, even_q, odd_d, odd_q;
  logic [9:0]       imm_even_d, imm_even_q;
  logic [17:0]      imm_odd_d, imm_odd_q;
  logic [31:0]      pc_out_d, pc_out_q;
  logic             br_first_d, br_first_q;

  assign in0 = in_slot0;
  assign in1 = in_slot1;

  function automatic logic src_ready(input slot_t s);
    return !((s.uses_ra && sb_q[s.ra] != '0) || (s.uses_rb && sb_q[s.rb] != '0) ||
             (s.uses_rc && sb_q[s.rc] != '0));
  endfunction

  function automatic logic reads_rt(input slot_t young, input slot_t old);
    return (old.unit_id != '0) &&
           ((young.uses_ra && young.ra == old.rt) || (young.uses_rb && young.rb == old.rt) ||
            (young.uses_rc && young.rc == old.rt));
  endfunction

  function automatic pipe_out_t to_pipe(input slot_t s);
    return '{unit_id: s.unit_id, opcode: s.opcode, ra: s.ra, rb: s.rb, rc: s.rc, rt: s.rt};
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Issue decision and handshake; a flush suppresses all issue for the cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    issue0    = 1'b0;
    issue1    = 1'b0;
    held_done = 1'b0;
    if (!branch_taken) begin
      case (state_q)
        EMPTY: held_done = 1'b1;
        PAIR: begin
          issue0    = src_ready(held_q[0]);
          issue1    = issue0 && (!held_q[1].valid ||
                      (src_ready(held_q[1]) && held_q[1].pipe != held_q[0].pipe &&
                       !reads_rt(held_q[1], held_q[0]) &&
                       !(held_q[0].is_branch && held_q[1].pipe)));
          held_done = issue1;
        end
        SECOND: begin
          issue1    = src_ready(held_q[1]);
          held_done = issue1;
        end
        default: ;
      endcase
    end
    in_ready = held_done;
    accept   = in_valid && held_done;
  end

  always_comb begin
    state_d = state_q;
    if (branch_taken)             state_d = EMPTY;
    else if (held_done) begin
      if (accept && in0.valid)      state_d = PAIR;
      else if (accept && in1.valid) state_d = SECOND;
      else                          state_d = EMPTY;
    end else if (issue0)          state_d = SECOND;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q[0] <= '0;
      held_q[1] <= '0;
      pc_q      <= '0;
    end else if (accept) begin
      held_q[0] <= in0;
      held_q[1] <= in1;
      pc_q      <= in_pc;
    end
  end

  // Routing and scoreboard update; the younger slot's set wins on a shared rt.
  assign go = {issue1 && held_q[1].valid, issue0};

  always_comb begin
    even_d     = NOP_PIPE;
    odd_d      = NOP_PIPE;
    imm_even_d = '0;
    imm_odd_d  = '0;
    pc_out_d   = pc_out_q;
    for (int r = 0; r < NREG; r++) sb_d[r] = (sb_q[r] != '0) ? sb_q[r] - LAT_W'(1) : '0;
    for (int k = 0; k < 2; k++) begin
      if (go[k]) begin
        if (held_q[k].pipe) begin
          odd_d     = to_pipe(held_q[k]);
          imm_odd_d = held_q[k].imm18;
        end else begin
          even_d     = to_pipe(held_q[k]);
          imm_even_d = held_q[k].imm18[9:0];
        end
        if (held_q[k].unit_id != '0) sb_d[held_q[k].rt] = held_q[k].lat;
      end
    end
    if (issue0)       pc_out_d = pc_q;
    else if (go[1])   pc_out_d = pc_q + 32'd4;
    br_first_d = go[0] && go[1] && held_q[0].is_branch && held_q[0].pipe && !held_q[1].pipe;
  end

  // NOTE: the scoreboard is reset explicitly; a stale countdown would stall a fresh stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) sb_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) sb_q[r] <= sb_d[r];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      even_q     <= NOP_PIPE;
      odd_q      <= NOP_PIPE;
      imm_even_q <= '0;
      imm_odd_q  <= '0;
      pc_out_q   <= '0;
      br_first_q <= 1'b0;
    end else begin
      even_q     <= even_d;
      odd_q      <= odd_d;
      imm_even_q <= imm_even_d;
      imm_odd_q  <= imm_odd_d;
      pc_out_q   <= pc_out_d;
      br_first_q <= br_first_d;
    end
  end

  assign rf_unit_id_even    = even_q.unit_id;
  assign rf_opcode_even     = even_q.opcode;
  assign addr_ra_rd_even    = even_q.ra;
  assign addr_rb_rd_even    = even_q.rb;
  assign addr_rc_rd_even    = even_q.rc;
  assign rf_addr_rt_wt_even = even_q.rt;
  assign rf_unit_id_odd     = odd_q.unit_id;
  assign rf_opcode_odd      = odd_q.opcode;
  assign addr_ra_rd_odd     = odd_q.ra;
  assign addr_rb_rd_odd     = odd_q.rb;
  assign addr_rc_rd_odd     = odd_q.rc;
  assign rf_addr_rt_wt_odd  = odd_q.rt;
  assign rf_imm7_even       = imm_even_q[6:0];
  assign rf_imm10_even      = imm_even_q;
  assign rf_imm7_odd        = imm_odd_q[6:0];
  assign rf_imm10_odd       = imm_odd_q[9:0];
  assign rf_imm16_odd       = imm_odd_q[15:0];
  assign rf_imm18_odd       = imm_odd_q;
  assign PC                 = pc_out_q;
  assign br_first_instr     = br_first_q;

endmodule

// File: tb/tb_spu_dual_issue_dispatch.sv
// Directed bench for spu_dual_issue_dispatch: a table of dual-issue pairs streamed at full
// throughput, then hand-written split, RAW, flush and reset sequences.
module tb_spu_dual_issue_dispatch;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, branch_taken;
  logic [68:0] slot0, slot1;
  logic [31:0] in_pc;
  logic [2:0]  rf_unit_id_even, rf_unit_id_odd;
  logic [10:0] rf_opcode_even, rf_opcode_odd;
  logic [6:0]  addr_ra_rd_even, addr_rb_rd_even, addr_rc_rd_even;
  logic [6:0]  addr_ra_rd_odd, addr_rb_rd_odd, addr_rc_rd_odd;
  logic [6:0]  rf_addr_rt_wt_even, rf_addr_rt_wt_odd;
  logic [6:0]  rf_imm7_even, rf_imm7_odd;
  logic [9:0]  rf_imm10_even, rf_imm10_odd;
  logic [15:0] rf_imm16_odd;
  logic [17:0] rf_imm18_odd;
  logic [31:0] PC;
  logic        br_first_instr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spu_dual_issue_dispatch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_slot0(slot0), .in_slot1(slot1), .in_pc(in_pc), .branch_taken(branch_taken),
    .rf_unit_id_even(rf_unit_id_even), .rf_unit_id_odd(rf_unit_id_odd),
    .rf_opcode_even(rf_opcode_even), .rf_opcode_odd(rf_opcode_odd),
    .addr_ra_rd_even(addr_ra_rd_even), .addr_rb_rd_even(addr_rb_rd_even),
    .addr_rc_rd_even(addr_rc_rd_even), .addr_ra_rd_odd(addr_ra_rd_odd),
    .addr_rb_rd_odd(addr_rb_rd_odd), .addr_rc_rd_odd(addr_rc_rd_odd),
    .rf_addr_rt_wt_even(rf_addr_rt_wt_even), .rf_addr_rt_wt_odd(rf_addr_rt_wt_odd),
    .rf_imm7_even(rf_imm7_even), .rf_imm7_odd(rf_imm7_odd),
    .rf_imm10_even(rf_imm10_even), .rf_imm10_odd(rf_imm10_odd),
    .rf_imm16_odd(rf_imm16_odd), .rf_imm18_odd(rf_imm18_odd),
    .PC(PC), .br_first_instr(br_first_instr)
  );

  // Observed pipe bundles: {unit, opcode, ra, rb, rc, rt, imm18}; even carries imm10 only.
  logic [59:0] even_obs, odd_obs;
  logic [39:0] imm_obs;
  assign even_obs = {rf_unit_id_even, rf_opcode_even, addr_ra_rd_even, addr_rb_rd_even,
                     addr_rc_rd_even, rf_addr_rt_wt_even, 8'd0, rf_imm10_even};
  assign odd_obs  = {rf_unit_id_odd, rf_opcode_odd, addr_ra_rd_odd, addr_rb_rd_odd,
                     addr_rc_rd_odd, rf_addr_rt_wt_odd, rf_imm18_odd};
  assign imm_obs  = {rf_imm7_even, rf_imm7_odd, rf_imm10_odd, rf_imm16_odd};

  typedef struct packed {
    logic [68:0] s0, s1;
    logic [31:0] pc;
    logic [59:0] ev, od;
    logic [31:0] epc;
    logic        brf;
  } vec_t;

  vec_t vt [4];

  // uses = {uses_ra, uses_rb, uses_rc}
  function automatic logic [68:0] mk(int pipe, int br, int uses, int lat, int unit, int opc,
                                     int ra, int rb, int rc, int rt, int imm);
    return {1'b1, 1'(pipe), 1'(br), 3'(uses), 3'(lat), 3'(unit), 11'(opc),
            7'(ra), 7'(rb), 7'(rc), 7'(rt), 18'(imm)};
  endfunction

  function automatic logic [59:0] pf(int unit, int opc, int ra, int rb, int rc, int rt, int imm);
    return {3'(unit), 11'(opc), 7'(ra), 7'(rb), 7'(rc), 7'(rt), 18'(imm)};
  endfunction

  function automatic logic [39:0] eimm(logic [59:0] ev, logic [59:0] od);
    return {ev[6:0], od[6:0], od[9:0], od[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [68:0] a, input logic [68:0] b,
                       input logic [31:0] pc);
    in_valid = v;
    slot0    = a;
    slot1    = b;
    in_pc    = pc;
  endtask

  initial begin
    // Independent pairs: sources never written by an earlier entry, so each dual-issues.
    vt[0] = '{s0: mk(0,0,3'b110,2,1,'h010, 1, 2,0, 3,'h00005),
              s1: mk(1,0,3'b100,6,3,'h020, 1, 0,0, 4,'h003F0), pc: 32'h100,
              ev: pf(1,'h010, 1, 2,0, 3,'h00005), od: pf(3,'h020, 1,0,0, 4,'h003F0),
              epc: 32'h100, brf: 1'b0};
    vt[1] = '{s0: mk(1,0,3'b110,4,4,'h030,21,22,0,20,'h2ABCD),
              s1: mk(0,0,3'b101,2,1,'h011,24, 0,9,23,'h0007F), pc: 32'h200,
              ev: pf(1,'h011,24, 0,9,23,'h0007F), od: pf(4,'h030,21,22,0,20,'h2ABCD),
              epc: 32'h200, brf: 1'b0};
    vt[2] = '{s0: mk(1,1,3'b100,0,5,'h040,30, 0,0, 0,'h000AB),
              s1: mk(0,0,3'b110,2,1,'h012,25,26,0,31,'h00200), pc: 32'h300,
              ev: pf(1,'h012,25,26,0,31,'h00200), od: pf(5,'h040,30,0,0, 0,'h000AB),
              epc: 32'h300, brf: 1'b1};
    vt[3] = '{s0: mk(0,0,3'b100,2,1,'h013,27, 0,0,40,'h003FF),
              s1: mk(1,1,3'b100,0,5,'h041,28, 0,0, 0,'h1F00F), pc: 32'h400,
              ev: pf(1,'h013,27, 0,0,40,'h003FF), od: pf(5,'h041,28,0,0, 0,'h1F00F),
              epc: 32'h400, brf: 1'b0};

    reset        = 1'b1;
    branch_taken = 1'b0;
    drive(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_even", 64'(even_obs), 64'(0));
    check("rst_odd", 64'(odd_obs), 64'(0));
    check("rst_pc", 64'(PC), 64'(0));
    check("rst_brf", 64'(br_first_instr), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(1));
    @(negedge clk) reset = 1'b0;
    step();

    // Streaming: pair i is accepted while pair i-1 issues; its outputs appear two edges later.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vt[i].s0, vt[i].s1, vt[i].pc);
      #1;
      check($sformatf("v%0d_ready", i), 64'(in_ready), 64'(1));
      step();
      if (i > 0) begin
        check($sformatf("v%0d_even", i-1), 64'(even_obs), 64'(vt[i-1].ev));
        check($sformatf("v%0d_odd", i-1), 64'(odd_obs), 64'(vt[i-1].od));
        check($sformatf("v%0d_imm", i-1), 64'(imm_obs), 64'(eimm(vt[i-1].ev, vt[i-1].od)));
        check($sformatf("v%0d_pc", i-1), 64'(PC), 64'(vt[i-1].epc));
        check($sformatf("v%0d_brf", i-1), 64'(br_first_instr), 64'(vt[i-1].brf));
      end
    end
    drive(1'b0, '0, '0, '0);
    step();
    check("v3_even", 64'(even_obs), 64'(vt[3].ev));
    check("v3_odd", 64'(odd_obs), 64'(vt[3].od));
    check("v3_imm", 64'(imm_obs), 64'(eimm(vt[3].ev, vt[3].od)));
    check("v3_pc", 64'(PC), 64'(vt[3].epc));
    check("v3_brf", 64'(br_first_instr), 64'(vt[3].brf));
    step();
    check("idle_even", 64'(even_obs), 64'(0));
    check("idle_odd", 64'(odd_obs), 64'(0));

    // Structural split: two even adds; second issues alone one cycle later with PC+4.
    drive(1'b1, mk(0,0,3'b110,2,1,'h014,1,2,0,5,'h11), mk(0,0,3'b110,2,1,'h015,1,2,0,6,'h22),
          32'h500);
    #1 check("split_accept", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, '0, '0, '0);
    #1 check("split_ready_low", 64'(in_ready), 64'(0));
    step();
    check("split_first_even", 64'(even_obs), 64'(pf(1,'h014,1,2,0,5,'h11)));
    check("split_first_odd", 64'(odd_obs), 64'(0));
    check("split_first_pc", 64'(PC), 64'(32'h500));
    #1 check("split_second_ready", 64'(in_ready), 64'(1));
    step();
    check("split_second_even", 64'(even_obs), 64'(pf(1,'h015,1,2,0,6,'h22)));
    check("split_second_pc", 64'(PC), 64'(32'h504));

    // RAW: fm r10 (lat 6) issues; the odd reader is held 6 cycles, then issues.
    drive(1'b1, mk(0,0,3'b110,6,2,'h050,1,2,0,10,0), '0, 32'h600);
    step();
    drive(1'b1, mk(1,0,3'b100,3,3,'h021,10,0,0,12,'h12345), '0, 32'h700);
    #1 check("raw_accept", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, '0, '0, '0);
    check("raw_fm_even", 64'(even_obs), 64'(pf(2,'h050,1,2,0,10,0)));
    check("raw_fm_pc", 64'(PC), 64'(32'h600));
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("raw_stall%0d_ready", k), 64'(in_ready), 64'(0));
      step();
      check($sformatf("raw_stall%0d_odd", k), 64'(odd_obs), 64'(0));
    end
    #1 check("raw_go_ready", 64'(in_ready), 64'(1));
    step();
    check("raw_reader_odd", 64'(odd_obs), 64'(pf(3,'h021,10,0,0,12,'h12345)));
    check("raw_reader_pc", 64'(PC), 64'(32'h700));

    // Intra-pair dependency: slot1 reads slot0's rt (lat 2) -> split, then 2-cycle wait.
    drive(1'b1, mk(0,0,3'b100,2,1,'h016,1,0,0,7,0), mk(1,0,3'b100,6,3,'h022,7,0,0,8,'h3FFFF),
          32'h800);
    #1 check("intra_accept", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, '0, '0, '0);
    #1 check("intra_split_ready", 64'(in_ready), 64'(0));
    step();
    check("intra_first_even", 64'(even_obs), 64'(pf(1,'h016,1,0,0,7,0)));
    check("intra_first_odd", 64'(odd_obs), 64'(0));
    check("intra_first_pc", 64'(PC), 64'(32'h800));
    for (int k = 0; k < 2; k++) begin
      #1 check($sformatf("intra_wait%0d_ready", k), 64'(in_ready), 64'(0));
      step();
      check($sformatf("intra_wait%0d_odd", k), 64'(odd_obs), 64'(0));
    end
    #1 check("intra_go_ready", 64'(in_ready), 64'(1));
    step();
    check("intra_second_odd", 64'(odd_obs), 64'(pf(3,'h022,7,0,0,8,'h3FFFF)));
    check("intra_second_imm", 64'(imm_obs), 64'({7'd0, 7'h7F, 10'h3FF, 16'hFFFF}));
    check("intra_second_pc", 64'(PC), 64'(32'h804));

    // Flush while SECOND is stalled on r50 (lat 7), then reset mid-stall.
    drive(1'b1, mk(0,0,3'b100,7,2,'h051,1,0,0,50,0), mk(1,0,3'b100,1,3,'h023,50,0,0,51,'h15),
          32'h900);
    step();
    drive(1'b0, '0, '0, '0);
    step();
    check("flush_first_pc", 64'(PC), 64'(32'h900));
    branch_taken = 1'b1;
    #1 check("flush_ready_low", 64'(in_ready), 64'(0));
    step();
    branch_taken = 1'b0;
    check("flush_even_nop", 64'(even_obs), 64'(0));
    check("flush_odd_nop", 64'(odd_obs), 64'(0));
    drive(1'b1, mk(1,0,3'b100,1,3,'h024,50,0,0,52,0), '0, 32'hA00);
    #1 check("flush_empty_ready", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, '0, '0, '0);
    #1 check("flush_sb_kept", 64'(in_ready), 64'(0));
    step();
    check("flush_stall_odd", 64'(odd_obs), 64'(0));
    #2 reset = 1'b1;
    #1;
    check("areset_pc", 64'(PC), 64'(0));
    check("areset_odd", 64'(odd_obs), 64'(0));
    check("areset_ready", 64'(in_ready), 64'(1));
    @(negedge clk) reset = 1'b0;
    step();
    drive(1'b1, mk(1,0,3'b100,1,3,'h024,50,0,0,52,0), '0, 32'hB00);
    #1 check("post_reset_accept", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, '0, '0, '0);
    step();
    check("post_reset_odd", 64'(odd_obs), 64'(pf(3,'h024,50,0,0,52,0)));
    check("post_reset_pc", 64'(PC), 64'(32'hB00));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
